// File: rtl/timer_pkg.sv
// Shared state, digit types and the one-second BCD decrement used by the MM:SS countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t m1;
      bcd_t m2;
      bcd_t s1;
      bcd_t s2;
   } mmss_t;

   typedef struct packed {
      mmss_t val;
      logic  zero;
   } bcd_dec_t;

   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t DIG_MAX      = 4'd9;

   // 00:00 saturates instead of underflowing; zero flags a 00:00 result.
   function automatic bcd_dec_t bcd_dec(input mmss_t v);
      bcd_dec_t r;
      r.val = v;
      if (v.s2 != 4'd0) begin
         r.val.s2 = v.s2 - 4'd1;
      end else begin
         r.val.s2 = DIG_MAX;
         if (v.s1 != 4'd0) begin
            r.val.s1 = v.s1 - 4'd1;
         end else begin
            r.val.s1 = SEC_TENS_MAX;
            if (v.m2 != 4'd0) begin
               r.val.m2 = v.m2 - 4'd1;
            end else begin
               r.val.m2 = DIG_MAX;
               r.val.m1 = v.m1 - 4'd1;
            end
         end
      end
      if (v == '0) r.val = '0;
      r.zero = (r.val == '0);
      return r;
   endfunction

endpackage

// File: rtl/countdown_timer_core_tick_gen.sv
// Free-running tick divider: o_tick is combinational, high on the enabled cycle the count wraps.
// The count freezes while i_en is low and returns to zero on i_clr.
module tick_gen #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk_50M,
   input  logic rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int               CNT_W = $clog2(CLK_HZ);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == LAST);
   assign o_tick = i_en && w_last;

   always_ff @(posedge clk_50M) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/countdown_timer_core.sv
// BCD MM:SS countdown with preset table, pause/resume and expiry; load latency 1, first tick CLK_HZ cycles after start.
// AUTO_RELOAD_EN: expiry reloads the selected preset and keeps running instead of stopping in EXPIRED.
module countdown_timer_core
   import timer_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int NUM_MODES = 4,
   parameter int MODE_W    = $clog2(NUM_MODES)
) (
   input  logic                   clk_50M,
   input  logic                   rst,
   input  logic [NUM_MODES*16-1:0] preset_tbl,
   input  logic [MODE_W-1:0]      mode,
   input  logic                   load,
   input  logic                   start,
   input  logic                   hold,
   output logic [3:0]             bcd_m1,
   output logic [3:0]             bcd_m2,
   output logic [3:0]             bcd_s1,
   output logic [3:0]             bcd_s2,
   output logic                   tick,
   output logic                   running,
   output logic                   done,
   output logic                   expired
);

`ifdef AUTO_RELOAD_EN
   localparam bit AUTO_RELOAD = 1'b1;
`else
   localparam bit AUTO_RELOAD = 1'b0;
`endif

   state_t   r_state;
   state_t   w_next;
   mmss_t    r_val;
   mmss_t    w_preset;
   bcd_dec_t w_dec;
   logic     r_tick;
   logic     r_done;
   logic     w_tick_en;
   logic     w_wrap;
   logic     w_nonzero;

   // Out-of-range mode values fall back to entry 0.
   always_comb begin
      w_preset = mmss_t'(preset_tbl[15:0]);
      for (int k = 1; k < NUM_MODES; k++) begin
         if (int'(mode) == k) w_preset = mmss_t'(preset_tbl[16*k +: 16]);
      end
   end

   assign w_dec     = bcd_dec(r_val);
   assign w_nonzero = (r_val != '0);

   tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick_gen (
      .clk_50M (clk_50M),
      .rst     (rst),
      .i_en    (w_tick_en),
      .i_clr   (load),
      .o_tick  (w_wrap)
   );

   always_ff @(posedge clk_50M) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (load) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (start && !hold && (w_nonzero || AUTO_RELOAD)) w_next = RUN;
            RUN:     if (hold) w_next = PAUSE;
                     else if (w_wrap && w_dec.zero && !AUTO_RELOAD) w_next = EXPIRED;
            PAUSE:   if (start && !hold) w_next = RUN;
            EXPIRED: w_next = EXPIRED;
            default: w_next = IDLE;
         endcase
      end
   end

   // Hold and load both freeze the divider before a tick can fire.
   always_comb begin
      w_tick_en = (r_state == RUN) && !hold && !load;
      running   = (r_state == RUN);
      expired   = (r_state == EXPIRED);
   end

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         r_val  <= '0;
         r_tick <= 1'b0;
         r_done <= 1'b0;
      end else if (load) begin
         r_val  <= w_preset;
         r_tick <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_tick <= w_wrap;
         r_done <= w_wrap && w_dec.zero;
         if (w_wrap) begin
`ifdef AUTO_RELOAD_EN
            r_val <= w_dec.zero ? w_preset : w_dec.val;
`else
            r_val <= w_dec.val;
`endif
         end
      end
   end

   assign bcd_m1 = r_val.m1;
   assign bcd_m2 = r_val.m2;
   assign bcd_s1 = r_val.s1;
   assign bcd_s2 = r_val.s2;
   assign tick   = r_tick;
   assign done   = r_done;

endmodule
